// File: rtl/stepper_phase_seq.sv
// stepper_phase_seq
// Single-channel bipolar stepper sequencer. It produces the step strobe, the
// H-bridge inputs and polarity flags for both coils, the driver standby line
// and a PWM current reference that falls back to a lower hold current once
// the motor has been idle for HOLD_CYCLES clocks.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   enable              driver enable; when low every output is forced to 0
//   run                 continuous stepping at step_period clocks per step
//   dir                 1 = phase index increments, 0 = decrements
//   half_step           1 = half-step sequence, 0 = two-coil full-step
//   step_period         clocks per step in run mode, 0 = no stepping
//   step_req / step_ack single-step handshake used while run = 0
//   run_duty, hold_duty VREF duty while moving / after the hold timeout
//   motor_pulse         one-clock strobe on every step
//   ch1_phase_a/b       coil current positive
//   ch1_INA1..ch1_INB2  bridge inputs
//   ch1_STANBY          driver active
//   ch1_VREF            PWM current reference
module stepper_phase_seq #(
  parameter int PERIOD_W    = 16,
  parameter int HOLD_CYCLES = 27000000,
  parameter int PWM_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                run,
  input  logic                dir,
  input  logic                half_step,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic                step_req,
  output logic                step_ack,
  input  logic [PWM_W-1:0]    run_duty,
  input  logic [PWM_W-1:0]    hold_duty,
  output logic                motor_pulse,
  output logic                ch1_phase_a,
  output logic                ch1_phase_b,
  output logic                ch1_INA1,
  output logic                ch1_INA2,
  output logic                ch1_INB1,
  output logic                ch1_INB2,
  output logic                ch1_STANBY,
  output logic                ch1_VREF
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  // Coil drive state, encoded directly as the {IN1, IN2} bridge pair.
  typedef enum logic [1:0] {
    COIL_OFF = 2'b00,
    COIL_NEG = 2'b01,
    COIL_POS = 2'b10
  } coil_t;

  logic [2:0]          idx;
  logic [2:0]          delta;
  logic [2:0]          idx_step;
  logic [2:0]          idx_next;
  logic [PERIOD_W-1:0] period_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [PWM_W-1:0]    duty;
  logic                req_prev;
  logic                period_active;
  logic                period_fire;
  logic                req_fire;
  logic                step;
  coil_t               coil_a_next;
  coil_t               coil_b_next;

  function automatic coil_t coil_a_of(input logic [2:0] i);
    case (i)
      3'd0, 3'd6, 3'd7: coil_a_of = COIL_POS;
      3'd1, 3'd5:       coil_a_of = COIL_OFF;
      default:          coil_a_of = COIL_NEG;
    endcase
  endfunction

  function automatic coil_t coil_b_of(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: coil_b_of = COIL_POS;
      3'd3, 3'd7:       coil_b_of = COIL_OFF;
      default:          coil_b_of = COIL_NEG;
    endcase
  endfunction

  // Step sources. The period counter fires on ">=" rather than "==" so that
  // shrinking step_period below the current count fires on the next edge
  // instead of wrapping around. A held step_req only fires once because the
  // previous sample must have been low.
  always_comb begin
    period_active = enable && run && (step_period != '0);
    period_fire   = period_active && (period_cnt >= step_period - PERIOD_W'(1));
    req_fire      = enable && !run && step_req && !req_prev;
    step          = period_fire || req_fire;
  end

  // Index advance. In full-step mode an odd index moves by one so the
  // sequence realigns onto the two-coil (even) positions in the direction
  // of travel; dir and half_step are only looked at when a step happens.
  always_comb begin
    delta       = (half_step || idx[0]) ? 3'd1 : 3'd2;
    idx_step    = dir ? (idx + delta) : (idx - delta);
    idx_next    = step ? idx_step : idx;
    coil_a_next = coil_a_of(idx_next);
    coil_b_next = coil_b_of(idx_next);
  end

  // Current reference selection: hold current only once the idle timer has
  // saturated.
  always_comb begin
    duty = (hold_cnt == HOLD_MAX) ? hold_duty : run_duty;
  end

  // Step engine and bridge outputs. Bridge pins and polarity flags are taken
  // from the post-step index so they change on the same edge as motor_pulse.
  // STANBY and the bridge share the registered enable, so the bridge can
  // never be driven while the driver is in standby.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      period_cnt  <= '0;
      req_prev    <= 1'b0;
      motor_pulse <= 1'b0;
      step_ack    <= 1'b0;
      ch1_STANBY  <= 1'b0;
      ch1_INA1    <= 1'b0;
      ch1_INA2    <= 1'b0;
      ch1_INB1    <= 1'b0;
      ch1_INB2    <= 1'b0;
      ch1_phase_a <= 1'b0;
      ch1_phase_b <= 1'b0;
    end else begin
      req_prev    <= step_req;
      period_cnt  <= (!period_active || period_fire) ? '0 : period_cnt + PERIOD_W'(1);
      idx         <= idx_next;
      motor_pulse <= step;
      step_ack    <= req_fire;
      ch1_STANBY  <= enable;
      if (enable) begin
        {ch1_INA1, ch1_INA2} <= coil_a_next;
        {ch1_INB1, ch1_INB2} <= coil_b_next;
        ch1_phase_a          <= (coil_a_next == COIL_POS);
        ch1_phase_b          <= (coil_b_next == COIL_POS);
      end else begin
        {ch1_INA1, ch1_INA2} <= 2'b00;
        {ch1_INB1, ch1_INB2} <= 2'b00;
        ch1_phase_a          <= 1'b0;
        ch1_phase_b          <= 1'b0;
      end
    end
  end

  // Idle timer for the hold current: restarts on every step and while the
  // driver is disabled, saturates at HOLD_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (!enable || step) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Free-running VREF PWM. A strict compare gives a constant 0 at duty 0 and
  // a single low count at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= '0;
      ch1_VREF <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + PWM_W'(1);
      ch1_VREF <= enable && (pwm_cnt < duty);
    end
  end

endmodule
